// File: rtl/dragonfang_floating_point_pkg.sv
// Shared types and constants for the vector floating-point datapath.
// Entry layout packs data in the MSBs, then destination index, then exception flags.
package dragonfang_floating_point_pkg;

  localparam int VLEN            = 128;
  localparam int VREG_ADDR_WIDTH = 5;
  localparam int VREG_COUNT      = 32;
  localparam int FFLAGS_WIDTH    = 5;

  // IEEE exception flag bit positions within an fflags vector
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  typedef struct packed {
    logic [VLEN-1:0]            data;
    logic [VREG_ADDR_WIDTH-1:0] address;
    logic [FFLAGS_WIDTH-1:0]    fflags;
  } vfp_writeback_entry_t;

endpackage

// File: rtl/dragonfang_sync_fifo.sv
// In-order synchronous FIFO exposing per-slot valid bits and a tag field of each stored word.
// Head is visible one cycle after push (no bypass); push is refused while full even if popping.
module dragonfang_sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int TAG_LSB   = 0,
  parameter int TAG_WIDTH = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_valid,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_ready,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0]           slot_valid,
  output logic [DEPTH*TAG_WIDTH-1:0] slot_tag
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_fire;
  logic             pop_fire;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign push_fire = push_valid && !full;
  assign pop_fire  = pop_ready && !empty;
  assign pop_data  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

  // A slot is live when its distance from the read pointer is below the occupancy
  always_comb begin
    slot_valid = '0;
    slot_tag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
      slot_tag[i*TAG_WIDTH +: TAG_WIDTH] = mem[i][TAG_LSB +: TAG_WIDTH];
    end
  end

endmodule

// File: rtl/vector_floating_point_result_writeback.sv
// Buffers FMA results in order and drains them to the VRF write port; tracks sticky fflags and pending destinations.
// Results reach the head one cycle after push; result_ready depends only on registered occupancy.
module vector_floating_point_result_writeback
  import dragonfang_floating_point_pkg::*;
#(
  parameter int VLEN            = dragonfang_floating_point_pkg::VLEN,
  parameter int DEPTH           = 4,
  parameter int VREG_ADDR_WIDTH = dragonfang_floating_point_pkg::VREG_ADDR_WIDTH,
  parameter int FFLAGS_WIDTH    = dragonfang_floating_point_pkg::FFLAGS_WIDTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            result_valid,
  output logic                            result_ready,
  input  logic [VLEN-1:0]                 result_data,
  input  logic [VREG_ADDR_WIDTH-1:0]      result_address,
  input  logic [FFLAGS_WIDTH-1:0]         result_fflags,
  output logic                            vrf_write_enable,
  input  logic                            vrf_write_ready,
  output logic [VREG_ADDR_WIDTH-1:0]      vrf_write_address,
  output logic [VLEN-1:0]                 vrf_write_data,
  output logic [(2**VREG_ADDR_WIDTH)-1:0] pending_mask,
  input  logic                            fflags_clear,
  output logic [FFLAGS_WIDTH-1:0]         fflags_accumulated,
  output logic                            empty
);

  localparam int ENTRY_W = VLEN + VREG_ADDR_WIDTH + FFLAGS_WIDTH;

  vfp_writeback_entry_t             push_entry;
  vfp_writeback_entry_t             head_entry;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic                             pop;
  logic [DEPTH-1:0]                 slot_valid;
  logic [DEPTH*VREG_ADDR_WIDTH-1:0] slot_address;

  assign push_entry = '{data: result_data, address: result_address, fflags: result_fflags};

  dragonfang_sync_fifo #(
    .WIDTH     (ENTRY_W),
    .DEPTH     (DEPTH),
    .TAG_LSB   (FFLAGS_WIDTH),
    .TAG_WIDTH (VREG_ADDR_WIDTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (result_valid),
    .push_data  (push_entry),
    .pop_ready  (vrf_write_ready),
    .pop_data   (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .slot_valid (slot_valid),
    .slot_tag   (slot_address)
  );

  assign result_ready      = !fifo_full;
  assign vrf_write_enable  = !fifo_empty;
  assign empty             = fifo_empty;
  assign vrf_write_address = head_entry.address;
  assign vrf_write_data    = head_entry.data;
  assign pop               = vrf_write_enable && vrf_write_ready;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) pending_mask[slot_address[i*VREG_ADDR_WIDTH +: VREG_ADDR_WIDTH]] = 1'b1;
    end
  end

  // A clear racing a retirement keeps the retiring entry's flags
  always_ff @(posedge clock) begin
    if (reset) begin
      fflags_accumulated <= '0;
    end else if (fflags_clear) begin
      fflags_accumulated <= pop ? head_entry.fflags : '0;
    end else if (pop) begin
      fflags_accumulated <= fflags_accumulated | head_entry.fflags;
    end
  end

endmodule

// File: tb/tb_vector_floating_point_result_writeback.sv
// Directed bench with a scoreboard queue: pushes enqueue expected writes, a monitor checks each VRF handshake.
module tb_vector_floating_point_result_writeback;

  logic         clock = 1'b0;
  logic         reset;
  logic         result_valid;
  logic         result_ready;
  logic [127:0] result_data;
  logic [4:0]   result_address;
  logic [4:0]   result_fflags;
  logic         vrf_write_enable;
  logic         vrf_write_ready;
  logic [4:0]   vrf_write_address;
  logic [127:0] vrf_write_data;
  logic [31:0]  pending_mask;
  logic         fflags_clear;
  logic [4:0]   fflags_accumulated;
  logic         empty;

  typedef struct {
    logic [4:0]   addr;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   acc;

  vector_floating_point_result_writeback dut (
    .clock              (clock),
    .reset              (reset),
    .result_valid       (result_valid),
    .result_ready       (result_ready),
    .result_data        (result_data),
    .result_address     (result_address),
    .result_fflags      (result_fflags),
    .vrf_write_enable   (vrf_write_enable),
    .vrf_write_ready    (vrf_write_ready),
    .vrf_write_address  (vrf_write_address),
    .vrf_write_data     (vrf_write_data),
    .pending_mask       (pending_mask),
    .fflags_clear       (fflags_clear),
    .fflags_accumulated (fflags_accumulated),
    .empty              (empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int k);
    logic [31:0] w;
    w = 32'hDEAD0000 + 32'(k);
    return {w, w, w, w};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Offers one result for up to max_cycles; returns at 1ns after the accepting (or last) edge
  task automatic try_push(input logic [4:0] a, input logic [127:0] d, input logic [4:0] f,
                          input int max_cycles, output bit accepted);
    exp_t e;
    result_valid   = 1'b1;
    result_address = a;
    result_data    = d;
    result_fflags  = f;
    accepted       = 1'b0;
    for (int c = 0; c < max_cycles && !accepted; c++) begin
      @(negedge clock);
      if (result_ready) begin
        accepted = 1'b1;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
      end
      @(posedge clock);
      #1;
    end
    result_valid = 1'b0;
  endtask

  // Monitor: every handshake seen before the edge must match the oldest expected write
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && vrf_write_enable && vrf_write_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d with no expected entry", vrf_write_address);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 128'(vrf_write_address), 128'(e.addr));
          check("wr_data", vrf_write_data, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; result_valid = 1'b0; result_data = '0; result_address = '0;
    result_fflags = '0; vrf_write_ready = 1'b0; fflags_clear = 1'b0;
    cyc(2);
    check("rst_empty", 128'(empty), 128'd1);
    check("rst_wen", 128'(vrf_write_enable), 128'd0);
    check("rst_mask", 128'(pending_mask), 128'd0);
    check("rst_ready", 128'(result_ready), 128'd1);
    check("rst_flags", 128'(fflags_accumulated), 128'd0);
    reset = 1'b0;

    // Single result
    vrf_write_ready = 1'b1;
    try_push(5'd3, {4{32'hDEADBEEF}}, 5'b00001, 4, acc);
    check("t1_accept", 128'(acc), 128'd1);
    check("t1_wen", 128'(vrf_write_enable), 128'd1);
    check("t1_addr", 128'(vrf_write_address), 128'd3);
    check("t1_mask", 128'(pending_mask), 128'h8);
    cyc(1);
    check("t1_wen_after", 128'(vrf_write_enable), 128'd0);
    check("t1_flags", 128'(fflags_accumulated), 128'b00001);
    check("t1_mask_after", 128'(pending_mask), 128'd0);

    // Fill and backpressure
    vrf_write_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      try_push(5'(k), mk(k), 5'b0, 2, acc);
      check("t2_accept", 128'(acc), 128'd1);
    end
    check("t2_full_ready", 128'(result_ready), 128'd0);
    check("t2_mask", 128'(pending_mask), 128'h1E);
    try_push(5'd5, mk(5), 5'b0, 3, acc);
    check("t2_fifth_refused", 128'(acc), 128'd0);
    check("t2_mask_hold", 128'(pending_mask), 128'h1E);
    vrf_write_ready = 1'b1;
    cyc(3);
    check("t2_one_left", 128'(empty), 128'd0);
    cyc(1);
    check("t2_drained", 128'(empty), 128'd1);
    vrf_write_ready = 1'b0;

    // Simultaneous push and pop at occupancy 2, wrapping the pointers
    try_push(5'd8, mk(8), 5'b0, 2, acc);
    try_push(5'd9, mk(9), 5'b0, 2, acc);
    vrf_write_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      try_push(5'(10 + k), mk(10 + k), 5'b0, 1, acc);
      check("t3_accept", 128'(acc), 128'd1);
    end
    vrf_write_ready = 1'b0;
    check("t3_two_left", 128'(pending_mask), 128'h000C_0000);
    vrf_write_ready = 1'b1;
    cyc(2);
    check("t3_drained", 128'(empty), 128'd1);
    vrf_write_ready = 1'b0;

    // Duplicate destination
    try_push(5'd7, mk(70), 5'b0, 2, acc);
    try_push(5'd7, mk(71), 5'b0, 2, acc);
    check("t4_mask_two", 128'(pending_mask), 128'h80);
    vrf_write_ready = 1'b1; cyc(1); vrf_write_ready = 1'b0;
    check("t4_mask_one", 128'(pending_mask), 128'h80);
    vrf_write_ready = 1'b1; cyc(1); vrf_write_ready = 1'b0;
    check("t4_mask_none", 128'(pending_mask), 128'd0);

    // Flag clear alone, accumulation, then clear racing a pop
    fflags_clear = 1'b1; cyc(1); fflags_clear = 1'b0;
    check("t5_clear_alone", 128'(fflags_accumulated), 128'd0);
    vrf_write_ready = 1'b1;
    try_push(5'd1, mk(100), 5'b10000, 2, acc);
    cyc(1);
    check("t5_acc_nv", 128'(fflags_accumulated), 128'b10000);
    vrf_write_ready = 1'b0;
    try_push(5'd2, mk(101), 5'b00100, 2, acc);
    check("t5_flags_not_at_push", 128'(fflags_accumulated), 128'b10000);
    fflags_clear = 1'b1; vrf_write_ready = 1'b1;
    cyc(1);
    fflags_clear = 1'b0; vrf_write_ready = 1'b0;
    check("t5_clear_race", 128'(fflags_accumulated), 128'b00100);
    check("t5_empty", 128'(empty), 128'd1);

    // Reset with entries buffered
    for (int k = 0; k < 3; k++) try_push(5'(20 + k), mk(200 + k), 5'b11111, 2, acc);
    check("t6_mask_before", 128'(pending_mask), 128'h0070_0000);
    reset = 1'b1;
    cyc(1);
    exp_q.delete();
    check("t6_empty", 128'(empty), 128'd1);
    check("t6_wen", 128'(vrf_write_enable), 128'd0);
    check("t6_mask", 128'(pending_mask), 128'd0);
    check("t6_flags", 128'(fflags_accumulated), 128'd0);
    reset = 1'b0;
    vrf_write_ready = 1'b1;
    cyc(5);
    check("t6_still_empty", 128'(empty), 128'd1);
    check("t6_flags_hold", 128'(fflags_accumulated), 128'd0);
    vrf_write_ready = 1'b0;

    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
